// File: rtl/alarm_ctrl.sv
// alarm_ctrl: alarm ring/snooze/stop sequencer; define ALARM_CTRL_BEEP_EN for a 1 s on/off buzzer
module alarm_ctrl #(
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_SECS = 9,
  parameter int MAX_SNOOZE  = 3
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              sec_tick,
  input  logic                              match,
  input  logic                              alarm_on,
  input  logic                              snooze,
  input  logic                              stop,
  output logic                              ring,
  output logic                              snoozing,
  output logic [1:0]                        state,
  output logic [$clog2(MAX_SNOOZE+1)-1:0]   snooze_cnt
);
  localparam int SW = $clog2(MAX_SNOOZE + 1);
  localparam int CW = $clog2((RING_SECS > SNOOZE_SECS ? RING_SECS : SNOOZE_SECS) + 1);
  localparam logic [SW-1:0] MAX_S    = SW'(MAX_SNOOZE);
  localparam logic [CW-1:0] RING_END = CW'(RING_SECS - 1);
  localparam logic [CW-1:0] SNZ_END  = CW'(SNOOZE_SECS - 1);
  typedef enum logic [1:0] {IDLE = 2'd0, RINGING = 2'd1, SNOOZE = 2'd2} state_e;
  state_e state_q, state_d;
  logic [CW-1:0] sec_q, sec_d;
  logic [SW-1:0] cnt_q, cnt_d;
  logic match_q, ring_q, snoozing_q, ring_d, trig;
  assign trig = match & ~match_q;
  always_comb begin
    state_d = state_q;
    sec_d   = sec_q;
    cnt_d   = cnt_q;
    case (state_q)
      RINGING:
        if (stop) state_d = IDLE;
        else if (snooze && cnt_q < MAX_S) begin
          state_d = SNOOZE;
          cnt_d   = cnt_q + 1'b1;
          sec_d   = '0;
        end else if (sec_tick) begin
          sec_d = sec_q + 1'b1;
          if (sec_q == RING_END) state_d = IDLE;
        end
      SNOOZE:
        if (stop) state_d = IDLE;
        else if (sec_tick) begin
          sec_d = sec_q + 1'b1;
          if (sec_q == SNZ_END) begin
            state_d = RINGING;
            sec_d   = '0;
          end
        end
      default: begin
        state_d = trig ? RINGING : IDLE;
        cnt_d   = '0;
        sec_d   = '0;
      end
    endcase
    if (!alarm_on) state_d = IDLE;
    if (state_d == IDLE) begin
      sec_d = '0;
      cnt_d = '0;
    end
  end
`ifdef ALARM_CTRL_BEEP_EN
  logic beep_q, beep_d;
  // phase restarts "on" at every entry to RINGING, flips per second while staying
  assign beep_d = (state_q != RINGING) | (beep_q ^ sec_tick);
  assign ring_d = (state_d == RINGING) & beep_d;
  always_ff @(posedge clk)
    if (reset) beep_q <= 1'b0;
    else beep_q <= beep_d;
`else
  assign ring_d = state_d == RINGING;
`endif
  always_ff @(posedge clk)
    if (reset) begin
      state_q    <= IDLE;
      sec_q      <= '0;
      cnt_q      <= '0;
      match_q    <= 1'b1;
      ring_q     <= 1'b0;
      snoozing_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sec_q      <= sec_d;
      cnt_q      <= cnt_d;
      match_q    <= match;
      ring_q     <= ring_d;
      snoozing_q <= state_d == SNOOZE;
    end
  assign ring       = ring_q;
  assign snoozing   = snoozing_q;
  assign state      = state_q;
  assign snooze_cnt = cnt_q;
endmodule
